// File: rtl/logic_serial_seq.sv
// Bit-serial AND/OR/XOR/NOT sequencer: one result bit per clock, LSB first.
// Result assembles in a right-shifting register; done strobes with a zero flag.
module logic_serial_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   s,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  op_a_q, op_a_d;
    logic [N-1:0]  op_b_q, op_b_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  result_q, result_d;
    logic          zero_q, zero_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fbit;
    logic [N-1:0]  shifted;

    always_comb begin
        fbit = 1'b0;
        case (op_q)
            2'b00:   fbit = op_a_q[0] & op_b_q[0];
            2'b01:   fbit = op_a_q[0] | op_b_q[0];
            2'b10:   fbit = op_a_q[0] ^ op_b_q[0];
            default: fbit = ~op_a_q[0];
        endcase
    end

    // New bit enters at the MSB so the first-computed bit ends up in bit 0.
    assign shifted = {fbit, result_q[N-1:1]};

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    op_a_d   = a;
                    op_b_d   = b;
                    op_d     = s;
                    cnt_d    = '0;
                    result_d = '0;
                end
            end
            S_RUN: begin
                result_d = shifted;
                op_a_d   = op_a_q >> 1;
                op_b_d   = op_b_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    zero_d  = (shifted == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_logic_serial_seq.sv
// Bench for logic_serial_seq: directed ops, expected results queued,
// monitor pops and compares on every done strobe.
module tb_logic_serial_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       zero;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    logic [4:0] sb[$];

    logic_serial_seq #(.N(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .s(s),
        .busy(busy),
        .done(done),
        .result(result),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got result %0h expected no done",
                         result);
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e[4:1]));
                check("sb_zero", 32'(zero), 32'(e[0]));
                check("sb_busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                          input logic [1:0] is, input logic [3:0] er,
                          input logic ez, output int lat, output int bcnt);
        @(negedge clk);
        start = 1'b1;
        a = ia;
        b = ib;
        s = is;
        sb.push_back({er, ez});
        lat = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (done !== 1'b1 && lat < 20);
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 20");
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int d0;
        int dpos[$];
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        s = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        reset = 1'b0;

        run_op(4'b1100, 4'b1010, 2'b00, 4'b1000, 1'b0, lat, bcnt);
        check("and_latency", 32'(lat), 32'd5);
        check("and_busy_cycles", 32'(bcnt), 32'd4);
        run_op(4'b1100, 4'b1010, 2'b01, 4'b1110, 1'b0, lat, bcnt);
        run_op(4'b1100, 4'b1010, 2'b10, 4'b0110, 1'b0, lat, bcnt);
        run_op(4'b1100, 4'b1111, 2'b11, 4'b0011, 1'b0, lat, bcnt);
        run_op(4'b0101, 4'b1010, 2'b00, 4'b0000, 1'b1, lat, bcnt);

        // OR after a zero result: zero must hold until this op completes
        @(negedge clk);
        start = 1'b1;
        a = 4'b0101;
        b = 4'b1010;
        s = 2'b01;
        sb.push_back({4'b1111, 1'b0});
        @(negedge clk);
        start = 1'b0;
        check("accept_clears_result", 32'(result), 32'd0);
        check("zero_held_in_run", 32'(zero), 32'd1);
        check("busy_after_accept", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        check("zero_held_late_run", 32'(zero), 32'd1);
        repeat (2) @(negedge clk);

        // Inputs churn and a second start during RUN must be ignored
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1;
        a = 4'b1111;
        b = 4'b1111;
        s = 2'b10;
        sb.push_back({4'b0000, 1'b1});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = 4'($urandom);
            b = 4'($urandom);
            s = 2'($urandom);
            start = (i == 1);
        end
        start = 1'b0;
        check("ignored_start_single_done", 32'(done_cnt - d0), 32'd1);

        // Reset in the third RUN cycle aborts with no done
        @(negedge clk);
        d0 = done_cnt;
        start = 1'b1;
        a = 4'b1111;
        b = 4'b0000;
        s = 2'b01;
        repeat (3) @(negedge clk) start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_op(4'b0001, 4'b0010, 2'b01, 4'b0011, 1'b0, lat, bcnt);
        check("after_abort_latency", 32'(lat), 32'd5);

        // start held high: one operation every 6 cycles
        @(negedge clk);
        start = 1'b1;
        a = 4'b0110;
        b = 4'b0011;
        s = 2'b10;
        repeat (3) sb.push_back({4'b0101, 1'b0});
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) dpos.push_back(n);
            if (busy === 1'b1 && done === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL busy_in_done: got busy 1 expected 0 at %0d", n);
            end
            if (n >= 17) start = 1'b0;
        end
        check("stream_done_count", 32'(dpos.size()), 32'd3);
        if (dpos.size() == 3) begin
            check("stream_done0", 32'(dpos[0]), 32'd5);
            check("stream_done1", 32'(dpos[1]), 32'd11);
            check("stream_done2", 32'(dpos[2]), 32'd17);
        end

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
